out_mem_sequencer: RTL and testbench

- Sequencer and arbiter in front of the per-filter output memory (32-bit words, 128 deep, byte-lane writes selected by a 2-bit offset, block preload via read/M, dump via writeOut).
- Shares the single byte-write port between N_REQ result producers using round-robin arbitration.
- Packs granted bytes into consecutive words starting at a base address, then issues one writeOut and pulses done.
- Also sequences single-cycle preload (read) commands between jobs.

---
 rtl/out_mem_sequencer_pkg.sv | 32 +++
 rtl/out_mem_sequencer_if.sv | 38 +++
 rtl/out_mem_sequencer_rr_arbiter.sv | 35 +++
 rtl/out_mem_sequencer.sv | 149 ++++++++++++++
 tb/tb_out_mem_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/out_mem_sequencer_pkg.sv
// Shared types and constants for the output-memory sequencer.
package out_mem_sequencer_pkg;

  // Words in the per-filter output memory; addresses wrap modulo this value.
  localparam int DEPTH     = 128;
  // Largest job: every byte lane of every word.
  localparam int MAX_BYTES = DEPTH * 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_COLLECT = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Byte counts above the memory capacity are clamped to a full dump.
  function automatic logic [9:0] clamp_count(input logic [9:0] c);
    if (c > 10'(MAX_BYTES)) return 10'(MAX_BYTES);
    else return c;
  endfunction

  // Word address of a byte: base plus word index, wrapped to the 7-bit
  // address space of a 128-word memory (bit 7 is always 0).
  function automatic logic [7:0] word_addr(input logic [7:0] base,
                                           input logic [7:0] word_idx);
    logic [7:0] sum;
    sum = base + word_idx;
    return {1'b0, sum[6:0]};
  endfunction

endpackage

// File: rtl/out_mem_sequencer_if.sv
// Producer byte bus and output-memory command bus seen by the sequencer.
//
// Handshake: a producer holds req[i] high with its byte stable on
// data[8i+7:8i]; the byte is consumed at the rising clock edge of any cycle in
// which grant[i] is high, and the producer presents its next byte afterwards.
// grant is combinational from req within the same cycle and is at most one-hot.
interface out_mem_sequencer_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   grant;

  logic       mem_write;
  logic       mem_read;
  logic       mem_load;
  logic       mem_writeOut;
  logic [7:0] mem_address;
  logic [7:0] mem_M;
  logic [1:0] mem_offset;
  logic [7:0] mem_in;

  // Sequencer side.
  modport master (
    input  req, data,
    output grant,
    output mem_write, mem_read, mem_load, mem_writeOut,
    output mem_address, mem_M, mem_offset, mem_in
  );

  // Producers and memory side.
  modport slave (
    output req, data,
    input  grant,
    input  mem_write, mem_read, mem_load, mem_writeOut,
    input  mem_address, mem_M, mem_offset, mem_in
  );
endinterface

// File: rtl/out_mem_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at pointer and
// grants the first requester found. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    pointer,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  localparam logic [PW:0] N_W = (PW + 1)'(N_REQ);

  // Rotating priority search, first hit from pointer wins.
  always_comb begin
    logic [PW:0] idx;
    grant  = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, pointer} + (PW + 1)'(i);
      if (idx >= N_W) idx = idx - N_W;
      if (enable && !valid && req[idx[PW-1:0]]) begin
        valid                = 1'b1;
        winner               = idx[PW-1:0];
        grant[idx[PW-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_mem_sequencer.sv
// Sequencer/arbiter in front of the per-filter output memory: collects bytes
// from N_REQ producers round-robin, packs them into consecutive words from a
// base address, then dumps with writeOut and pulses done. Also issues
// single-cycle preload commands between jobs.
module out_mem_sequencer
  import out_mem_sequencer_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 base_addr,
  input  logic [9:0]                 byte_count,
  input  logic                       preload_req,
  input  logic [7:0]                 preload_base,
  out_mem_sequencer_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output state_t                     state_dbg
);

  localparam int          PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_REQ - 1);

  state_t        state, state_next;
  logic [9:0]    cnt;
  logic [9:0]    count_q;
  logic [7:0]    base_q;
  logic [7:0]    preload_q;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;

  logic             arb_en;
  logic [N_REQ-1:0] arb_grant;
  logic [PW-1:0]    arb_winner;
  logic             arb_valid;
  logic [7:0]       sel_byte;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (bus.req),
    .pointer (ptr),
    .enable  (arb_en),
    .grant   (arb_grant),
    .winner  (arb_winner),
    .valid   (arb_valid)
  );

  assign state_dbg = state;
  assign ptr_next  = (arb_winner == LAST) ? '0 : arb_winner + 1'b1;

  // Byte of the granted producer (grant is one-hot or zero).
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) sel_byte = bus.data[8*i +: 8];
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Job context: latched command fields, byte counter and arbitration pointer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      count_q   <= '0;
      base_q    <= '0;
      preload_q <= '0;
      ptr       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) begin
            base_q  <= base_addr;
            count_q <= clamp_count(byte_count);
          end else if (preload_req) begin
            preload_q <= preload_base;
          end
        end
        ST_COLLECT: begin
          if (arb_valid) begin
            cnt <= cnt + 10'd1;
            ptr <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and all memory/producer-facing outputs.
  always_comb begin
    state_next       = state;
    arb_en           = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    bus.grant        = arb_grant;
    bus.mem_write    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_load     = 1'b0;
    bus.mem_writeOut = 1'b0;
    bus.mem_address  = '0;
    bus.mem_M        = '0;
    bus.mem_offset   = '0;
    bus.mem_in       = '0;
    case (state)
      ST_IDLE: begin
        busy         = 1'b0;
        bus.mem_load = 1'b1;
        if (start) begin
          // A zero-byte job still dumps and signals completion.
          state_next = (byte_count == '0) ? ST_FLUSH : ST_COLLECT;
        end else if (preload_req) begin
          state_next = ST_PRELOAD;
        end
      end
      ST_PRELOAD: begin
        bus.mem_read = 1'b1;
        bus.mem_M    = preload_q;
        state_next   = ST_IDLE;
      end
      ST_COLLECT: begin
        arb_en = 1'b1;
        if (arb_valid) begin
          bus.mem_write   = 1'b1;
          bus.mem_in      = sel_byte;
          bus.mem_offset  = cnt[1:0];
          bus.mem_address = word_addr(base_q, cnt[9:2]);
          if (cnt + 10'd1 == count_q) state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        bus.mem_writeOut = 1'b1;
        state_next       = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_out_mem_sequencer.sv
// Directed bench for out_mem_sequencer: producer model, scoreboard of
// expected memory byte writes, and per-job completion checks.
module tb_out_mem_sequencer;
  import out_mem_sequencer_pkg::*;

  localparam int N = 4;
  localparam int W = N + 8 + 2 + 8;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [9:0] byte_count = '0;
  logic       preload_req = 1'b0;
  logic [7:0] preload_base = '0;
  logic       busy;
  logic       done;
  state_t     state_dbg;

  out_mem_sequencer_if #(.N_REQ(N)) bus ();

  out_mem_sequencer #(.N_REQ(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .byte_count   (byte_count),
    .preload_req  (preload_req),
    .preload_base (preload_base),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .state_dbg    (state_dbg)
  );

  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  int wr_cnt = 0, rd_cnt = 0, wo_cnt = 0, done_cnt = 0;
  logic [7:0] exp_m = '0;
  logic prev_wo = 1'b0;

  // ---------------- producer model ----------------
  logic [7:0] prod_base[N];
  int         prod_idx[N];
  logic [N-1:0] g_seen = '0;

  initial begin
    for (int i = 0; i < N; i++) begin
      prod_base[i] = '0;
      prod_idx[i]  = 0;
    end
    bus.req = '0;
  end

  always_comb begin
    bus.data = '0;
    for (int i = 0; i < N; i++) bus.data[8*i +: 8] = prod_base[i] + 8'(prod_idx[i]);
  end

  // A producer advances to its next byte after each edge that consumed one.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < N; i++) if (g_seen[i]) prod_idx[i] = prod_idx[i] + 1;
    g_seen = '0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int p, input int addr, input int off, input int d);
    logic [N-1:0] g;
    g = '0;
    g[p] = 1'b1;
    return {g, 8'(addr), 2'(off), 8'(d)};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    int n;
    g_seen = bus.grant;
    if (!reset) begin
      n = int'(bus.mem_write) + int'(bus.mem_read) + int'(bus.mem_writeOut);
      chk("strobe_excl", 32'(n <= 1), 32'd1);
      chk("load_idle", 32'(bus.mem_load), 32'(!busy));
      if (bus.req == '0) chk("no_req_no_write", 32'(bus.mem_write), 32'd0);
      if (bus.mem_write) begin
        wr_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", 32'(exp_q.size()), 32'd1);
        else chk("write", 32'({bus.grant, bus.mem_address, bus.mem_offset, bus.mem_in}),
                 32'(exp_q.pop_front()));
      end
      if (bus.mem_read) begin
        rd_cnt++;
        chk("read_M", 32'(bus.mem_M), 32'(exp_m));
      end
      if (bus.mem_writeOut) wo_cnt++;
      if (done) begin
        done_cnt++;
        chk("done_after_wo", 32'(prev_wo), 32'd1);
      end
      prev_wo = bus.mem_writeOut;
    end else begin
      prev_wo = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    tick();
    reset       = 1'b1;
    start       = 1'b0;
    preload_req = 1'b0;
    bus.req     = '0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) prod_idx[i] = 0;
  endtask

  task automatic start_job(input logic [7:0] b, input logic [9:0] c, input logic pre);
    tick();
    start       = 1'b1;
    base_addr   = b;
    byte_count  = c;
    preload_req = pre;
    preload_base = 8'h99;
    tick();
    start       = 1'b0;
    preload_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk(tag, 32'(done_cnt - d0), 32'd1);
    @(negedge clock);
    #1;
    chk("busy_fall", 32'(busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w0, wo0, d0, r0, k;

    // Reset state, sampled while reset is held.
    tick();
    #1;
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_write", 32'(bus.mem_write), 32'd0);
    chk("rst_read", 32'(bus.mem_read), 32'd0);
    chk("rst_wo", 32'(bus.mem_writeOut), 32'd0);
    chk("rst_load", 32'(bus.mem_load), 32'd1);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    tick();
    reset = 1'b0;

    // Single producer 2, base 0x10, 8 bytes.
    prod_base[2] = 8'hA0;
    for (int j = 0; j < 8; j++) exp_q.push_back(pack(2, 'h10 + j / 4, j % 4, 'hA0 + j));
    w0 = wr_cnt; wo0 = wo_cnt;
    bus.req = 4'b0100;
    start_job(8'h10, 10'd8, 1'b0);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done(40, "t1_done");
    chk("t1_writes", 32'(wr_cnt - w0), 32'd8);
    chk("t1_wo", 32'(wo_cnt - wo0), 32'd1);

    // All producers requesting: order 0,1,2,3,0,1,2,3 after reset.
    do_reset();
    for (int i = 0; i < N; i++) prod_base[i] = 8'(16 * i + 1);
    for (int j = 0; j < 8; j++)
      exp_q.push_back(pack(j % 4, 'h40 + j / 4, j % 4, 16 * (j % 4) + 1 + j / 4));
    bus.req = 4'hF;
    start_job(8'h40, 10'd8, 1'b0);
    wait_done(40, "t2_done");

    // Sparse requests from producer 1, 3 bytes.
    do_reset();
    prod_base[1] = 8'h55;
    for (int j = 0; j < 3; j++) exp_q.push_back(pack(1, 'h22, j, 'h55 + j));
    w0 = wr_cnt; d0 = done_cnt;
    start_job(8'h22, 10'd3, 1'b0);
    k = 0;
    while (done_cnt == d0 && k < 30) begin
      bus.req = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      k++;
    end
    bus.req = '0;
    chk("t3_done", 32'(done_cnt - d0), 32'd1);
    chk("t3_writes", 32'(wr_cnt - w0), 32'd3);
    chk("t3_queue", 32'(exp_q.size()), 32'd0);

    // Address wrap: base 0x7F.
    do_reset();
    prod_base[0] = 8'hC0;
    for (int j = 0; j < 8; j++) exp_q.push_back(pack(0, (j < 4) ? 'h7F : 'h00, j % 4, 'hC0 + j));
    bus.req = 4'b0001;
    start_job(8'h7F, 10'd8, 1'b0);
    wait_done(40, "t4_done");

    // start and preload_req together: job wins, preload dropped.
    do_reset();
    prod_base[3] = 8'h11;
    for (int j = 0; j < 4; j++) exp_q.push_back(pack(3, 'h30, j, 'h11 + j));
    r0 = rd_cnt;
    bus.req = 4'b1000;
    start_job(8'h30, 10'd4, 1'b1);
    wait_done(40, "t5_done");
    bus.req = '0;
    tick(); tick(); tick();
    chk("t5_no_read", 32'(rd_cnt - r0), 32'd0);

    // Preload alone: one cycle of read with M = 0x20.
    r0 = rd_cnt;
    exp_m = 8'h20;
    tick();
    preload_req  = 1'b1;
    preload_base = 8'h20;
    tick();
    preload_req = 1'b0;
    chk("t6_state", 32'(state_dbg), 32'(ST_PRELOAD));
    tick();
    chk("t6_busy", 32'(busy), 32'd0);
    tick();
    chk("t6_reads", 32'(rd_cnt - r0), 32'd1);

    // Zero-byte job: writeOut and done, no writes.
    w0 = wr_cnt; wo0 = wo_cnt;
    start_job(8'h50, 10'd0, 1'b0);
    wait_done(10, "t7_done");
    chk("t7_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t7_wo", 32'(wo_cnt - wo0), 32'd1);

    // Reset in COLLECT after 2 of 6 bytes.
    do_reset();
    prod_base[0] = 8'h70;
    for (int j = 0; j < 2; j++) exp_q.push_back(pack(0, 'h60, j, 'h70 + j));
    w0 = wr_cnt; wo0 = wo_cnt; d0 = done_cnt;
    bus.req = 4'b0001;
    start_job(8'h60, 10'd6, 1'b0);
    k = 0;
    while (wr_cnt - w0 < 2 && k < 50) begin
      @(negedge clock);
      #1;
      k++;
    end
    chk("t8_two_writes", 32'(wr_cnt - w0), 32'd2);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #3;
    chk("t8_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("t8_busy", 32'(busy), 32'd0);
    tick();
    reset   = 1'b0;
    bus.req = '0;
    for (int i = 0; i < N; i++) prod_idx[i] = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("t8_no_wo", 32'(wo_cnt - wo0), 32'd0);
    chk("t8_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t8_queue", 32'(exp_q.size()), 32'd0);

    // count=600 clamps to 512 bytes (128 words, wrapping from 0x05).
    for (int i = 0; i < N; i++) prod_base[i] = 8'(64 * i);
    for (int j = 0; j < 512; j++)
      exp_q.push_back(pack(j % 4, ('h05 + j / 4) % 128, j % 4, 64 * (j % 4) + j / 4));
    w0 = wr_cnt; wo0 = wo_cnt;
    bus.req = 4'hF;
    start_job(8'h05, 10'd600, 1'b0);
    wait_done(700, "t9_done");
    bus.req = '0;
    chk("t9_writes", 32'(wr_cnt - w0), 32'd512);
    chk("t9_wo", 32'(wo_cnt - wo0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
